// File: rtl/pixel_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_cfg_pkg
// Description : Shared types and constants for the pixel configuration path.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_cfg_pkg;

    localparam int c_def_data_w = 32;
    localparam int c_def_words  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_LOAD      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_cfg_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : pixel_cfg_edge_det
// Description : Synchronizes div_clk into clkin and emits rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
import pixel_cfg_pkg::*;

module pixel_cfg_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic div_clk,
    output logic rise_ev,
    output logic fall_ev
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], div_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise_ev =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall_ev = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/pixel_cfg_serializer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_cfg_serializer
// Description : Shifts a WORDS x DATA_W config frame out MSB first on div_clk
//               falling edges, then strobes cfg_load. Optional readback of the
//               matrix shift chain is enabled by macro CFG_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
import pixel_cfg_pkg::*;

module pixel_cfg_serializer #(
    parameter int DATA_W      = c_def_data_w,
    parameter int WORDS       = c_def_words,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              div_clk,
    input  logic              start,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              cfg_sdata,
    output logic              cfg_load,
    output logic              busy,
    output logic              done,
`ifdef CFG_READBACK_EN
    input  logic              cfg_sdin,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
`endif
    output logic              err
);

    localparam int c_bit_w  = cnt_w(DATA_W);
    localparam int c_word_w = cnt_w(WORDS);

    state_t              r_state, w_next_state;
    logic                w_rise, w_fall;
    logic [DATA_W-1:0]   r_shreg, r_nbuf, w_shifted;
    logic                r_nbuf_full;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [c_word_w-1:0] r_words_req, r_words_sent;
    logic                r_sdata, r_load, r_busy, r_done, r_err;
    logic                w_hs, w_last_bit, w_more;
    logic                w_begin, w_load_word, w_shift, w_underrun;
    logic                w_load_set, w_load_clr, w_finish;

    pixel_cfg_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_det (
        .clkin   (clkin),
        .rst     (rst),
        .div_clk (div_clk),
        .rise_ev (w_rise),
        .fall_ev (w_fall)
    );

    assign wr_ready   = r_busy & ~r_nbuf_full & (r_words_req < c_word_w'(WORDS));
    assign w_hs       = wr_valid & wr_ready;
    assign w_last_bit = (r_bit_cnt == c_bit_w'(DATA_W));
    assign w_more     = (r_words_sent != c_word_w'(WORDS));
    assign w_shifted  = r_shreg << 1;

    always_ff @(posedge clkin) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_next_state = ST_FILL;
            ST_FILL:      if (r_nbuf_full && w_fall) w_next_state = ST_SHIFT;
            ST_SHIFT: begin
                // The final bit needs no further fall; its sampling rise is awaited next.
                if (w_last_bit && !w_more)                    w_next_state = ST_WAIT_RISE;
                else if (w_last_bit && w_fall && !r_nbuf_full) w_next_state = ST_FINISH;
            end
            ST_WAIT_RISE: if (w_rise) w_next_state = ST_LOAD;
            ST_LOAD:      if (w_fall && r_load) w_next_state = ST_FINISH;
            ST_FINISH:    w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_begin     = (r_state == ST_IDLE) & start;
        w_load_word = ((r_state == ST_FILL) & r_nbuf_full & w_fall) |
                      ((r_state == ST_SHIFT) & w_last_bit & w_more & w_fall & r_nbuf_full);
        w_shift     = (r_state == ST_SHIFT) & w_fall & ~w_last_bit;
        w_underrun  = (r_state == ST_SHIFT) & w_last_bit & w_more & w_fall & ~r_nbuf_full;
        w_load_set  = (r_state == ST_LOAD) & w_fall & ~r_load;
        w_load_clr  = (r_state == ST_LOAD) & w_fall &  r_load;
        w_finish    = (r_state == ST_FINISH);
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_shreg      <= '0;
            r_nbuf       <= '0;
            r_nbuf_full  <= 1'b0;
            r_bit_cnt    <= '0;
            r_words_req  <= '0;
            r_words_sent <= '0;
            r_sdata      <= 1'b0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_hs) begin
                r_nbuf      <= wr_data;
                r_nbuf_full <= 1'b1;
                r_words_req <= r_words_req + c_word_w'(1);
            end
            if (w_begin) begin
                r_busy       <= 1'b1;
                r_err        <= 1'b0;
                r_nbuf_full  <= 1'b0;
                r_bit_cnt    <= '0;
                r_words_req  <= '0;
                r_words_sent <= '0;
            end
            if (w_load_word) begin
                r_shreg      <= r_nbuf;
                r_sdata      <= r_nbuf[DATA_W-1];
                r_nbuf_full  <= 1'b0;
                r_bit_cnt    <= c_bit_w'(1);
                r_words_sent <= r_words_sent + c_word_w'(1);
            end
            if (w_shift) begin
                r_shreg   <= w_shifted;
                r_sdata   <= w_shifted[DATA_W-1];
                r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
            if (w_underrun) begin
                r_err   <= 1'b1;
                r_sdata <= 1'b0;
            end
            if (w_load_set) r_load <= 1'b1;
            if (w_load_clr) r_load <= 1'b0;
            if (w_finish) begin
                r_sdata     <= 1'b0;
                r_busy      <= 1'b0;
                r_nbuf_full <= 1'b0;
            end
        end
    end

    assign cfg_sdata = r_sdata;
    assign cfg_load  = r_load;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

`ifdef CFG_READBACK_EN
    logic [DATA_W-1:0]  r_rb_sh, r_rb_data, w_rb_next;
    logic [c_bit_w-1:0] r_rb_cnt;
    logic               r_rb_valid, w_rb_sample;

    assign w_rb_sample = w_rise & ((r_state == ST_SHIFT) | (r_state == ST_WAIT_RISE));
    assign w_rb_next   = (r_rb_sh << 1) | DATA_W'(cfg_sdin);

    always_ff @(posedge clkin) begin
        if (!rst) begin
            r_rb_sh    <= '0;
            r_rb_data  <= '0;
            r_rb_cnt   <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_begin) r_rb_cnt <= '0;
            if (w_rb_sample) begin
                r_rb_sh <= w_rb_next;
                if (r_rb_cnt == c_bit_w'(DATA_W - 1)) begin
                    r_rb_data  <= w_rb_next;
                    r_rb_valid <= 1'b1;
                    r_rb_cnt   <= '0;
                end else begin
                    r_rb_cnt <= r_rb_cnt + c_bit_w'(1);
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_cfg_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_cfg_serializer
// Description : Scoreboard bench: a behavioural matrix latches the serial
//               stream and is compared against frames queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_cfg_serializer;

    localparam int DW = 8;
    localparam int NW = 2;
    localparam int FW = DW * NW;

    logic          clkin    = 1'b0;
    logic          rst      = 1'b0;
    logic          div_clk  = 1'b0;
    logic          start    = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_ready, cfg_sdata, cfg_load, busy, done, err;
`ifdef CFG_READBACK_EN
    logic [DW-1:0] rb_data;
    logic          rb_valid;
    logic [DW-1:0] q_rb[$];
`endif

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] q_frame[$];
    bit            q_err[$];
    logic [FW-1:0] mshift = '0;
    logic          prev_load = 1'b0;
    int            load_w = 0;
    int            dcnt = 0;

    pixel_cfg_serializer #(
        .DATA_W(DW), .WORDS(NW), .SYNC_STAGES(2)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .div_clk   (div_clk),
        .start     (start),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .cfg_sdata (cfg_sdata),
        .cfg_load  (cfg_load),
        .busy      (busy),
        .done      (done),
`ifdef CFG_READBACK_EN
        .cfg_sdin  (cfg_sdata),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
`endif
        .err       (err)
    );

    always #5 clkin = ~clkin;

    // Divide-by-5: high for 2 clkin periods, low for 3.
    always @(negedge clkin) begin
        dcnt    <= (dcnt == 4) ? 0 : dcnt + 1;
        div_clk <= (dcnt == 4) || (dcnt == 0);
    end

    // Behavioural pixel matrix shift chain.
    always @(posedge div_clk) mshift <= {mshift[FW-2:0], cfg_sdata};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s required none", name, what);
    endtask

    // Monitor: pops expectations whenever the DUT presents load/done/readback.
    always @(posedge clkin) begin
        #1;
        if (rst) begin
            if (cfg_load && !prev_load) begin
                if (q_frame.size() == 0) fail("load", "unexpected cfg_load");
                else check("frame", 32'(mshift), 32'(q_frame.pop_front()));
                load_w = 1;
            end else if (cfg_load) begin
                load_w++;
            end
            if (!cfg_load && prev_load) check("load_width", load_w, 5);
            if (done) begin
                if (q_err.size() == 0) fail("done", "unexpected done");
                else begin
                    check("done_err", 32'(err), 32'(q_err.pop_front()));
                    check("done_busy", 32'(busy), 0);
                end
            end
`ifdef CFG_READBACK_EN
            if (rb_valid) begin
                if (q_rb.size() == 0) fail("rb", "unexpected rb_valid");
                else check("rb_data", 32'(rb_data), 32'(q_rb.pop_front()));
            end
`endif
        end
        prev_load = cfg_load;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        bit hs = 1'b0;
        wr_data  = w;
        wr_valid = 1'b1;
        for (int i = 0; i < 400 && !hs; i++) begin
            @(negedge clkin);
            hs = wr_ready;
            @(posedge clkin);
            #1;
        end
        wr_valid = 1'b0;
        if (!hs) fail("wr_handshake", "timeout");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (busy || q_err.size() != 0); i++) tick();
        if (busy || q_err.size() != 0) fail("idle_wait", "timeout");
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_sdata"}, 32'(cfg_sdata), 0);
        check({tag, "_load"},  32'(cfg_load),  0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_done"},  32'(done),      0);
        check({tag, "_err"},   32'(err),       0);
        check({tag, "_ready"}, 32'(wr_ready),  0);
    endtask

    task automatic run_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input int nsup, input bit restart);
        if (nsup == NW) begin
            q_frame.push_back({w0, w1});
            q_err.push_back(1'b0);
        end else begin
            q_err.push_back(1'b1);
        end
`ifdef CFG_READBACK_EN
        q_rb.push_back(w0);
        if (nsup == NW) q_rb.push_back(w1);
`endif
        pulse_start();
        check("start_busy", 32'(busy), 1);
        check("start_err_clr", 32'(err), 0);
        send_word(w0);
        if (nsup == NW) begin
            repeat ($urandom_range(0, 8)) tick();
            send_word(w1);
        end
        if (restart) begin
            repeat (10) tick();
            pulse_start();
        end
        wait_idle();
        check("frame_consumed", q_frame.size(), 0);
        check("err_after", 32'(err), (nsup == NW) ? 0 : 1);
`ifdef CFG_READBACK_EN
        check("rb_consumed", q_rb.size(), 0);
`endif
        repeat ($urandom_range(1, 12)) tick();
    endtask

    initial begin
        repeat (10) tick();
        outputs_zero("reset");
        rst = 1'b1;
        tick();

        // Writes outside a frame must never be accepted.
        wr_data  = 8'hFF;
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_wr_ready", 32'(wr_ready), 0);
        end
        wr_valid = 1'b0;
        tick();

        run_frame(8'hA5, 8'h3C, 2, 1'b0);
        run_frame(8'hA5, 8'h00, 1, 1'b0);
        run_frame(8'h5A, 8'hC3, 2, 1'b1);

        // Reset a few bits into an all-ones frame; nothing may survive.
        pulse_start();
        send_word(8'hFF);
        send_word(8'hFF);
        repeat (10) tick();
        check("midshift_sdata", 32'(cfg_sdata), 1);
        rst = 1'b0;
        tick();
        outputs_zero("midrst");
        tick();
        rst = 1'b1;
        tick();

        run_frame(8'h81, 8'h7E, 2, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_frame(DW'($urandom), DW'($urandom), (k == 3) ? 1 : 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_cfg_serializer.md
Name: pixel_cfg_serializer

Overview:
- Consumes the divide-by-5 configuration clock (div_clk) produced by the pixel-config clock divider.
- Serializes a frame of WORDS x DATA_W configuration bits onto cfg_sdata, MSB first, then issues a cfg_load latch strobe to the pixel matrix.
- Runs entirely on clkin; div_clk is treated as a sampled signal.
- Data changes on div_clk falling edges, so the matrix samples it stably on div_clk rising edges.

Parameters:
DATA_W, 32, bits per input word
WORDS, 4, words per configuration frame (>=1)
SYNC_STAGES, 2, synchronizer flops on div_clk (>=2)

Ports:
clkin  in  1  system clock; all logic on posedge
rst  in  1  reset, synchronous, active-low
div_clk  in  1  divided config clock from divider stage
start  in  1  begin frame (1-cycle pulse, honoured only in IDLE)
wr_data  in  DATA_W  next config word
wr_valid  in  1  wr_data valid
wr_ready  out  1  word accepted when wr_valid & wr_ready
cfg_sdata  out  1  serial config data to matrix
cfg_load  out  1  latch strobe to matrix
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse at frame end
err  out  1  sticky underrun flag, cleared by accepted start

Behaviour:
- Reset (rst=0 at posedge clkin): the following all go to 0:
  - outputs: cfg_sdata, cfg_load, busy, done, err, wr_ready
  - internal state: synchronizer, counters, buffers; FSM to IDLE
- Reset mid-frame discards the frame; cfg_load drops on that edge.
- Edge detect on div_clk:
  - synchronized div_clk feeds one more flop (prev).
  - rise_ev = sync & ~prev; fall_ev = ~sync & prev.
  - Latency from div_clk edge to event is SYNC_STAGES+1 clkin cycles.
- Word buffering: shift register (shreg) plus one-entry holding buffer (nbuf, nbuf_full).
  - wr_ready = busy & ~nbuf_full & words_requested < WORDS.
  - On a handshake, nbuf_full rises on the next edge.
- FSM states:
  - IDLE: start -> FILL. On transition: busy=1, err=0, counters cleared. start while busy is ignored.
  - FILL: wait for nbuf_full. At the next fall_ev, move nbuf to shreg, drive cfg_sdata=MSB, bit_cnt=1, go SHIFT.
  - SHIFT: each fall_ev shifts shreg left and drives the new MSB; bit_cnt increments.
    - When bit_cnt==DATA_W at a fall_ev and words remain: reload shreg from nbuf, drive MSB, bit_cnt=1.
    - If nbuf is empty at that point: err=1, cfg_sdata=0, go FINISH without load.
    - After the last bit of the last word: go WAIT_RISE.
  - WAIT_RISE: hold cfg_sdata until the next rise_ev, so the last bit is sampled. Then go LOAD.
  - LOAD: cfg_load=1 at the next fall_ev; cleared at the following fall_ev (one div_clk period wide). Then go FINISH.
  - FINISH: cfg_sdata=0, done=1 for one clkin, busy=0, go IDLE.
- Frame length is exactly WORDS*DATA_W rise_ev between the first driven bit and the load.
- Simultaneous events:
  - rise_ev and fall_ev cannot coincide.
  - wr handshake and a word-boundary fall_ev in the same cycle: the boundary uses nbuf contents present before the edge.
  - An empty nbuf at that boundary counts as underrun.
- wr_valid outside busy is never accepted.

Optional Feature:
- Macro: CFG_READBACK_EN.
- When defined:
  - Adds input cfg_sdin (matrix shift-chain output), plus outputs rb_data[DATA_W] and rb_valid.
  - cfg_sdin is sampled on every rise_ev in SHIFT and WAIT_RISE, assembled MSB first.
  - rb_valid pulses for one clkin when DATA_W bits have been collected.
  - rb_data holds its value until the next word; reset value 0.
- When undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pixel_cfg_pkg:
  - FSM state enum (IDLE, FILL, SHIFT, WAIT_RISE, LOAD, FINISH)
  - default DATA_W/WORDS constants
  - helper constant for counter widths via clog2.
- One sub-module: pixel_cfg_edge_det (SYNC_STAGES synchronizer plus rise/fall pulse generation), reused by other div_clk consumers.

Test Plan:
(DATA_W=8, WORDS=2; div_clk from a behavioural divide-by-5 of clkin.)
- Reset: hold rst=0 for 10 clkin -> all outputs 0, wr_ready=0.
- Nominal frame: start, then supply 0xA5, 0x3C -> cfg_sdata sampled at 16 successive div_clk rising edges = 1010010100111100. Then cfg_load high for exactly 5 clkin, done pulses once, busy=0, err=0.
- Underrun: start, supply only 0xA5 -> after 8 bits err=1, cfg_load never asserts, done pulses, busy=0. Next start clears err.
- Protocol: wr_valid with 0xFF in IDLE -> no handshake. start pulsed mid-frame -> frame unchanged, single done.
- Reset mid-shift: rst=0 after 5 bits, then a fresh 0x81, 0x7E frame -> outputs 0 immediately; new frame serializes correctly.
- CFG_READBACK_EN: loop cfg_sdata to cfg_sdin, frame 0xA5, 0x3C -> rb_valid pulses twice, with rb_data=0xA5 then 0x3C.
